// File: rtl/id_inst_queue.sv
// DEPTH-entry FIFO of {pc, inst} beats between IC fetch and the decoder.
// Flush or taken branch empties the queue and shows nop bubbles to ID.
module id_inst_queue #(
   parameter int DEPTH  = 4,
   parameter int PC_W   = 32,
   parameter int INST_W = 32,
   parameter int BYPASS = 0,
   localparam int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              br_e,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [PC_W-1:0]   in_pc,
   input  logic [INST_W-1:0] in_inst,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [PC_W-1:0]   out_pc,
   output logic [INST_W-1:0] out_inst,
   output logic [CNT_W-1:0]  count,
   output logic              stallreq
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

   logic [PC_W-1:0]   pc_mem   [DEPTH];
   logic [INST_W-1:0] inst_mem [DEPTH];
   logic [PTR_W-1:0]  rd_ptr;
   logic [PTR_W-1:0]  wr_ptr;
   logic              run;
   logic              kill;
   logic              empty;
   logic              pass_now;
   logic              push;
   logic              pop;
   logic              write_en;
   logic              pop_mem;
   logic              valid_raw;

   // Valid/ready: a beat moves on a side only when both valid and ready are high
   // in the same cycle; in_ready drops while full or while the pipe is being killed.
   assign kill     = flush | br_e;
   assign empty    = (count == '0);
   assign pass_now = (BYPASS != 0) && empty;
   assign in_ready = run & (count != FULL) & ~kill;
   assign push     = in_valid & in_ready;

   always_comb begin
      valid_raw = 1'b0;
      if (pass_now) valid_raw = in_valid & run;
      else          valid_raw = ~empty;
   end

   assign out_valid = valid_raw & ~kill;
   assign pop       = out_valid & out_ready;
   // A fall-through beat consumed in the same cycle never touches storage.
   assign write_en  = push & ~(pass_now & pop);
   assign pop_mem   = pop & ~empty;
   assign stallreq  = (count == FULL);

   always_comb begin
      out_pc   = '0;
      out_inst = '0;
      if (out_valid) begin
         if (pass_now) begin
            out_pc   = in_pc;
            out_inst = in_inst;
         end else begin
            out_pc   = pc_mem[rd_ptr];
            out_inst = inst_mem[rd_ptr];
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         run    <= 1'b0;
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         run <= 1'b1;
         if (kill) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
         end else begin
            if (write_en) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop_mem)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({write_en, pop_mem})
               2'b10:   count <= count + CNT_W'(1);
               2'b01:   count <= count - CNT_W'(1);
               default: count <= count;
            endcase
         end
      end
   end

   always_ff @(posedge clk) begin
      if (write_en) begin
         pc_mem[wr_ptr]   <= in_pc;
         inst_mem[wr_ptr] <= in_inst;
      end
   end

endmodule

// File: tb/tb_id_inst_queue.sv
// Directed bench for id_inst_queue: a registered instance checked against a
// scoreboard queue, plus a fall-through instance for the bypass path.
module tb_id_inst_queue;

   logic        clk = 1'b0;
   logic        rst;
   logic        flush, br_e;
   logic        in_valid, out_ready;
   logic [31:0] in_pc, in_inst;
   logic        in_ready, out_valid, stallreq;
   logic [31:0] out_pc, out_inst;
   logic [2:0]  count;

   logic        in_valid_b, out_ready_b;
   logic [31:0] in_pc_b, in_inst_b;
   logic        in_ready_b, out_valid_b, stallreq_b;
   logic [31:0] out_pc_b, out_inst_b;
   logic [2:0]  count_b;

   logic [63:0] exp_q[$];
   logic        mrun;
   logic        acc;
   int          checks = 0;
   int          errors = 0;

   always #5 clk = ~clk;

   id_inst_queue #(.DEPTH(4), .PC_W(32), .INST_W(32), .BYPASS(0)) u_reg (
      .clk(clk), .rst(rst), .flush(flush), .br_e(br_e),
      .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_inst(in_inst),
      .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_inst(out_inst),
      .count(count), .stallreq(stallreq)
   );

   id_inst_queue #(.DEPTH(4), .PC_W(32), .INST_W(32), .BYPASS(1)) u_byp (
      .clk(clk), .rst(rst), .flush(flush), .br_e(br_e),
      .in_valid(in_valid_b), .in_ready(in_ready_b), .in_pc(in_pc_b), .in_inst(in_inst_b),
      .out_valid(out_valid_b), .out_ready(out_ready_b), .out_pc(out_pc_b), .out_inst(out_inst_b),
      .count(count_b), .stallreq(stallreq_b)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   // One clock of the registered instance: called at a negedge with inputs set,
   // checks outputs against the scoreboard, then updates it across the edge.
   task automatic cycle();
      logic        kill, e_rdy, e_val, do_pop, do_push;
      logic [63:0] hd, beat;
      #2;
      kill  = flush | br_e;
      e_rdy = mrun && (exp_q.size() != 4) && !kill;
      e_val = (exp_q.size() != 0) && !kill;
      chk("in_ready", 64'(in_ready), 64'(e_rdy));
      chk("count", 64'(count), 64'(exp_q.size()));
      chk("stallreq", 64'(stallreq), 64'(exp_q.size() == 4));
      chk("out_valid", 64'(out_valid), 64'(e_val));
      if (e_val) begin
         hd = exp_q[0];
         chk("out_pc", 64'(out_pc), 64'(hd[63:32]));
         chk("out_inst", 64'(out_inst), 64'(hd[31:0]));
      end else begin
         chk("out_pc_bubble", 64'(out_pc), 64'd0);
         chk("out_inst_bubble", 64'(out_inst), 64'd0);
      end
      do_pop  = e_val && out_ready;
      do_push = in_valid && e_rdy;
      beat    = {in_pc, in_inst};
      acc     = do_push;
      @(posedge clk);
      if (kill) exp_q.delete();
      else begin
         if (do_pop)  void'(exp_q.pop_front());
         if (do_push) exp_q.push_back(beat);
      end
      mrun = 1'b1;
      @(negedge clk);
   endtask

   task automatic drive(input logic v, input logic [31:0] pc);
      in_valid = v;
      in_pc    = pc;
      in_inst  = $urandom_range(32'h7fff_ffff, 0);
   endtask

   initial begin
      int k;
      rst = 1'b0; flush = 1'b0; br_e = 1'b0;
      in_valid = 1'b0; out_ready = 1'b0; in_pc = '0; in_inst = '0;
      in_valid_b = 1'b0; out_ready_b = 1'b0; in_pc_b = '0; in_inst_b = '0;
      mrun = 1'b0; acc = 1'b0;

      // reset state
      @(negedge clk);
      #2;
      chk("rst_in_ready", 64'(in_ready), 64'd0);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_count", 64'(count), 64'd0);
      chk("rst_stallreq", 64'(stallreq), 64'd0);
      chk("rst_out_pc", 64'(out_pc), 64'd0);
      @(negedge clk);
      rst = 1'b1;
      cycle();   // in_ready still 0 before the first edge out of reset

      // 1: streaming with 1-cycle latency
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 32'hBFC0_0000 + 32'(i * 4));
         cycle();
      end
      drive(1'b0, '0);
      cycle();
      cycle();

      // 2: fill to DEPTH with the 5th beat held, then drain in order
      out_ready = 1'b0;
      k = 0;
      for (int i = 0; i < 7; i++) begin
         if (i == 5) out_ready = 1'b1;
         if (k < 5) drive(1'b1, 32'h0000_1000 + 32'(k));
         else       drive(1'b0, '0);
         cycle();
         if (acc) k++;
      end
      drive(1'b0, '0);
      for (int i = 0; i < 6; i++) cycle();
      chk("t2_all_accepted", 64'(k), 64'd5);
      chk("t2_drained", 64'(exp_q.size()), 64'd0);

      // 3: taken branch at count=3 kills queue and the incoming beat
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 32'h0000_2000 + 32'(i));
         cycle();
      end
      drive(1'b1, 32'h0000_2ABC);
      br_e = 1'b1;
      cycle();
      br_e = 1'b0;
      drive(1'b0, '0);
      out_ready = 1'b1;
      cycle();
      cycle();

      // flush with one beat stored
      drive(1'b1, 32'h0000_3000);
      out_ready = 1'b0;
      cycle();
      flush = 1'b1;
      cycle();
      flush = 1'b0;
      drive(1'b0, '0);
      cycle();

      // 4: steady push/pop at count=2 across several pointer wraps
      out_ready = 1'b0;
      for (int i = 0; i < 2; i++) begin
         drive(1'b1, 32'h0000_4000 + 32'(i));
         cycle();
      end
      out_ready = 1'b1;
      for (int i = 2; i < 14; i++) begin
         drive(1'b1, 32'h0000_4000 + 32'(i));
         cycle();
      end
      drive(1'b0, '0);
      for (int i = 0; i < 4; i++) cycle();
      chk("t4_drained", 64'(exp_q.size()), 64'd0);

      // 5: fall-through instance
      in_valid_b = 1'b1; out_ready_b = 1'b1;
      in_pc_b = 32'hBFC0_0100; in_inst_b = 32'h2402_0001;
      #2;
      chk("byp_in_ready", 64'(in_ready_b), 64'd1);
      chk("byp_out_valid", 64'(out_valid_b), 64'd1);
      chk("byp_out_inst", 64'(out_inst_b), 64'h2402_0001);
      chk("byp_out_pc", 64'(out_pc_b), 64'hBFC0_0100);
      @(negedge clk);
      chk("byp_count_after_pop", 64'(count_b), 64'd0);
      out_ready_b = 1'b0;
      in_pc_b = 32'hBFC0_0104; in_inst_b = 32'h2403_0002;
      @(negedge clk);
      in_valid_b = 1'b0; in_inst_b = '0; in_pc_b = '0;
      #2;
      chk("byp_count_stored", 64'(count_b), 64'd1);
      chk("byp_stored_valid", 64'(out_valid_b), 64'd1);
      chk("byp_stored_inst", 64'(out_inst_b), 64'h2403_0002);
      out_ready_b = 1'b1;
      @(negedge clk);
      out_ready_b = 1'b0;
      #2;
      chk("byp_count_empty", 64'(count_b), 64'd0);
      chk("byp_bubble_inst", 64'(out_inst_b), 64'd0);
      @(negedge clk);

      // 6: async reset between edges with count=2
      out_ready = 1'b0;
      for (int i = 0; i < 2; i++) begin
         drive(1'b1, 32'h0000_6000 + 32'(i));
         cycle();
      end
      drive(1'b0, '0);
      chk("t6_count_before", 64'(count), 64'd2);
      #3;
      rst = 1'b0;
      #1;
      chk("t6_out_valid", 64'(out_valid), 64'd0);
      chk("t6_count", 64'(count), 64'd0);
      chk("t6_out_pc", 64'(out_pc), 64'd0);
      exp_q.delete();
      mrun = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      cycle();
      cycle();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
